// File: rtl/risc_pkg.sv
// risc_pkg: RISC_PROC shared widths, fetch entry type, core reset PC and a saturating-increment helper.
package risc_pkg;
    localparam int INSTR_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam logic [ADDR_W_DEF-1:0] CORE_RESET_PC = '0;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch entries with push/pop, synchronous clear and occupancy flags.
module fetch_fifo
    import risc_pkg::*;
#(
    parameter type T = fetch_entry_t,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  T              wdata,
    output T              rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    T mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled fetch stage - owns the PC, issues to fixed-latency imem, buffers words in a FIFO.
// Optional FETCH_PERF_EN adds saturating redirect / stall / dropped-response counters.
module fetch_queue
    import risc_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CORE_RESET_PC)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_next,
    output logic               empty,
    output logic               full
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_redirects,
    output logic [15:0]        perf_stall_cycles,
    output logic [15:0]        perf_dropped
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc, inflight_pc;
    logic inflight, stale, accept, rsp_push, rsp_drop;
    logic [CW-1:0] count;
    entry_t head, wdata;

    // A FIFO slot is reserved for every outstanding request, so pushes never overflow.
    assign imem_req_valid = reset & ((count + CW'(inflight)) < CW'(DEPTH));
    assign imem_req_addr = fetch_pc;
    assign accept = imem_req_valid & imem_req_ready;
    assign rsp_push = inflight & ~stale & ~redirect_valid;
    assign rsp_drop = inflight & (stale | redirect_valid);
    assign wdata = '{instr: imem_rsp_data, pc: inflight_pc};

    assign out_valid = ~empty;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc = out_valid ? head.pc : '0;
    assign out_pc_next = out_valid ? head.pc + 1'b1 : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            inflight_pc <= '0;
            inflight <= 1'b0;
            stale <= 1'b0;
        end else begin
            fetch_pc <= redirect_valid ? redirect_pc : accept ? fetch_pc + 1'b1 : fetch_pc;
            inflight_pc <= fetch_pc;
            inflight <= accept;
            // A request accepted alongside a redirect fetched the old path.
            stale <= redirect_valid;
        end
    end

    fetch_fifo #(
        .T(entry_t),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .clear(redirect_valid),
        .push(rsp_push),
        .pop(out_ready),
        .wdata(wdata),
        .rdata(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_redirects <= '0;
            perf_stall_cycles <= '0;
            perf_dropped <= '0;
        end else begin
            perf_redirects <= sat_inc16(perf_redirects, redirect_valid);
            perf_stall_cycles <= sat_inc16(perf_stall_cycles, full & ~out_ready);
            perf_dropped <= sat_inc16(perf_dropped, rsp_drop);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with a scoreboard of expected fetch PCs checked by a monitor.
module tb_fetch_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic imem_req_ready = 1'b1;
    logic [15:0] imem_rsp_data = '0;
    logic out_ready = 1'b0;
    logic imem_req_valid, out_valid, empty, full;
    logic [15:0] imem_req_addr, out_instr, out_pc, out_pc_next;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_redirects, perf_stall_cycles, perf_dropped;
`endif

    int tests = 0;
    int fails = 0;
    int accepts = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e_pc, e_instr, e_next;

    always #5 clock = ~clock;

    fetch_queue dut (
        .clock(clock),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_pc_next(out_pc_next),
        .empty(empty),
        .full(full)
`ifdef FETCH_PERF_EN
        ,
        .perf_redirects(perf_redirects),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_dropped(perf_dropped)
`endif
    );

    // One-cycle instruction memory returning 0xA000 + address.
    always @(posedge clock) begin
        if (imem_req_valid && imem_req_ready) begin
            imem_rsp_data <= 16'hA000 + imem_req_addr;
            accepts <= accepts + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_seq(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 16'(i));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_out_instr"}, out_instr, 0);
        check({tag, "_out_pc"}, out_pc, 0);
        check({tag, "_out_pc_next"}, out_pc_next, 0);
    endtask

    // Monitor: every consumed head must be the next expected fetch PC.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got pc %0h expected no delivery", out_pc);
            end else begin
                e_pc = exp_q.pop_front();
                e_instr = 16'hA000 + e_pc;
                e_next = e_pc + 16'd1;
                check("sb_pc", out_pc, e_pc);
                check("sb_instr", out_instr, e_instr);
                check("sb_pc_next", out_pc_next, e_next);
            end
        end
    end

    initial begin
        int a0;
        repeat (3) tick();
        check_reset_outputs("rst");

        // Fill from reset with the consumer stalled.
        expect_seq(16'h0000, 64);
        a0 = accepts;
        reset = 1'b1;
        tick();
        check("lat_c1_valid", out_valid, 0);
        tick();
        check("lat_c2_valid", out_valid, 1);
        check("lat_c2_instr", out_instr, 16'hA000);
        check("lat_c2_pc", out_pc, 16'h0000);
        check("lat_c2_pc_next", out_pc_next, 16'h0001);
        repeat (8) tick();
        check("stall_reqs", accepts - a0, 4);
        check("stall_full", full, 1);
        check("stall_req_valid", imem_req_valid, 0);

        // Drain, then alternate memory readiness.
        out_ready = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 8; i++) begin
            imem_req_ready = ~i[0];
            tick();
        end
        imem_req_ready = 1'b1;
        repeat (6) tick();

        // Build 3 queued + 1 in flight, then redirect.
        out_ready = 1'b0;
        repeat (2) tick();
        check("pre_redir_req_valid", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        exp_q.delete();
        expect_seq(16'h0040, 16);
        tick();
        redirect_valid = 1'b0;
        check("redir_empty", empty, 1);
        check("redir_req_valid", imem_req_valid, 1);
        check("redir_req_addr", imem_req_addr, 16'h0040);
        tick();
        check("redir_stale_empty", empty, 1);
        tick();
        check("redir_valid", out_valid, 1);
        check("redir_pc", out_pc, 16'h0040);
        check("redir_instr", out_instr, 16'hA040);

        // Back-to-back redirects: the second target wins.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        exp_q.delete();
        expect_seq(16'h0020, 16);
        tick();
        redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        check("b2b_empty", empty, 1);
        repeat (2) tick();
        check("b2b_valid", out_valid, 1);
        check("b2b_pc", out_pc, 16'h0020);
        out_ready = 1'b1;
        repeat (10) tick();

        // PC wrap at the top of the address space.
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        exp_q.delete();
        expect_seq(16'hFFFF, 8);
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        check("wrap_valid", out_valid, 1);
        check("wrap_pc", out_pc, 16'hFFFF);
        check("wrap_pc_next", out_pc_next, 16'h0000);
        check("wrap_instr", out_instr, 16'h9FFF);
        out_ready = 1'b1;
        repeat (8) tick();

        // Reset mid-stream clears everything at once.
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (2) tick();
        check_reset_outputs("mid_rst_hold");
        expect_seq(16'h0000, 16);
        reset = 1'b1;
        #1;
        check("restart_req_valid", imem_req_valid, 1);
        check("restart_req_addr", imem_req_addr, 16'h0000);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised decoupled instruction-fetch stage for the RISC_PROC pipeline; successor to the single PC register plus IF/ID buffer fetch path.
- Owns the PC and issues sequential requests to a fixed-latency instruction memory.
- Buffers returned words in a DEPTH-entry FIFO, so ID stalls no longer freeze fetch.
- Accepts branch/jump redirects and discards stale in-flight words.

Parameters:
- INSTR_W, 16, instruction word width in bits.
- ADDR_W, 16, PC / instruction address width (word addressed).
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch target.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_W  fetch address (= fetch PC).
- imem_rsp_data  in  INSTR_W  word for the request accepted exactly one cycle earlier.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  ID consumes the head (the IF/ID write enable).
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  address of the head instruction.
- out_pc_next  out  ADDR_W  out_pc+1, feeds the branch adder.
- empty  out  1  no valid entries.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, count=0, inflight=0, rd/wr pointers=0. Outputs during reset: imem_req_valid=0, out_valid=0, empty=1, full=0, out_* = 0.
- Issue rule: imem_req_valid = (count + inflight < DEPTH); the slot is reserved before issue, so the FIFO can never overflow.
- Request acceptance (req_valid & req_ready): fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W. inflight <= 1 with the stale tag cleared. If not accepted, inflight <= 0.
- Response: the cycle after acceptance, if the request is not stale, write {imem_rsp_data, pc} at wr_ptr and set count +1. Latency from request to out_valid is 2 cycles on an empty queue.
- Pop: out_valid & out_ready sets count -1 and advances rd_ptr. Push and pop in the same cycle leave count unchanged; this holds even when full.
- Pointers wrap modulo DEPTH. Outputs are driven combinationally from the head registers. out_pc_next wraps modulo 2^ADDR_W.
- Redirect cycle:
  - fetch_pc <= redirect_pc; count <= 0; pointers reset.
  - Any inflight response arriving next cycle is dropped (stale tag set).
  - A request issued in the redirect cycle uses the old PC and is marked stale.
  - A pop handshake in the same cycle completes normally; the consumer flushes it.
  - A response arriving in the redirect cycle is dropped.
  - The first new-target request is issued the next cycle; out_valid rises no earlier than 2 cycles after redirect.
- Back-to-back redirects: the last one wins; each one re-stales in-flight work.
- Reset asserted mid-operation clears everything immediately; in-flight responses are never written.

Optional Feature:
- FETCH_PERF_EN defined: adds 16-bit saturating counters, all reset to 0.
  - perf_redirects: +1 per redirect_valid cycle.
  - perf_stall_cycles: +1 per cycle with full & !out_ready.
  - perf_dropped: +1 per discarded stale response.
  - All three are exposed as output ports.
- Undefined: the counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package risc_pkg holds:
  - INSTR_W/ADDR_W defaults;
  - the fetch_entry_t struct {instr, pc};
  - the RESET_PC constant shared with the core.
- One sub-module, fetch_fifo: parametrised storage with push/pop/clear, count, full/empty.
- fetch_queue keeps PC, issue, stale-tag logic and the counters.

Test Plan:
- Reset release, out_ready=1, req_ready=1, memory returns 16'hA000+addr -> out_valid first high at cycle 2 with out_instr=16'hA000, out_pc=0, out_pc_next=1; thereafter one instruction per cycle, pc 1,2,3.
- out_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 requests issued, full=1, imem_req_valid=0. Then out_ready=1 -> pc 0..3 then 4 delivered in order, no gap beyond 1 cycle.
- Redirect to 16'h0040 while 3 entries are queued and a request is in flight -> next-cycle empty=1; the stale response is not written; next out_pc=16'h0040, 2 cycles later.
- Redirects on two consecutive cycles (16'h0010 then 16'h0020) -> first out_pc=16'h0020; no 0x0010 word ever appears.
- req_ready toggled 1,0,1,0 -> no duplicated or skipped PCs; out_pc strictly sequential.
- With fetch_pc=16'hFFFF -> out_pc=16'hFFFF, out_pc_next=16'h0000, next out_pc=16'h0000. Assert reset mid-stream -> all outputs 0 / empty=1 immediately; restart at RESET_PC.
